uart_frame_sched: RTL
=====================

// Module: uart_frame_sched
// PURPOSE
// - Sequencer between the UART receive FIFO, a shared single-port frame RAM and the UART transmitter.
// - Captures received bytes into the RAM until a frame ends, then replays the whole frame out through the transmitter.
// - A frame ends on a terminator byte, an idle timeout or a full buffer.
// - Sole owner of the RAM port: capture and drain are time-multiplexed, never concurrent.
// PARAMETERS
// - ADDR_W        8        RAM address width; frame capacity = 2**ADDR_W bytes
// - TERM_BYTE     8'h0D    byte that closes a frame (stored and transmitted)
// - IDLE_CYC      480000   cycles without a new RX byte that close a non-empty frame (10 ms at 48 MHz)
// - RAM_RD_LAT    1        cycles from ram_addr to valid ram_rdata
// PORTS
// - clk           in   1       system clock
// - rst           in   1       asynchronous reset, active-high
// - rx_empty      in   1       RX FIFO empty flag
// - rx_data       in   8       RX FIFO q; valid the cycle after rx_rd
// - rx_rd         out  1       RX FIFO read request, 1-cycle pulse
// - ram_addr      out  ADDR_W  frame RAM address
// - ram_wdata     out  8       frame RAM write data
// - ram_wren      out  1       frame RAM write enable
// - ram_rdata     in   8       frame RAM read data
// - tx_data       out  8       byte to transmitter; held stable from tx_wr until tx_ti
// - tx_wr         out  1       transmitter start strobe, 1-cycle pulse
// - tx_ti         in   1       transmitter done, 1-cycle pulse per byte
// - frame_len     out  ADDR_W+1 length of the frame being drained; 0 when idle
// - busy          out  1       high in every state except IDLE
// - overflow      out  1       1-cycle pulse when a frame is closed because the buffer is full
// BEHAVIOUR
// - Reset (async): state=IDLE; all outputs 0; wr_ptr, rd_ptr and idle counter cleared. Reset mid-frame discards the frame.
//   The transmitter is reset by the same rst.
// - States: IDLE, C_POP, C_WR, D_ADDR, D_RD, D_SEND, D_WAIT.
// - IDLE/C_WR with !rx_empty -> C_POP: rx_rd=1 for 1 cycle.
// - C_POP -> C_WR: ram_addr=wr_ptr, ram_wdata=rx_data, ram_wren=1 for 1 cycle. wr_ptr++ and idle counter cleared.
//   Two cycles per captured byte.
// - C_WR frame close: rx_data==TERM_BYTE, or wr_ptr+1==2**ADDR_W (overflow pulse).
//   On close: frame_len<=wr_ptr+1 and go to D_ADDR. Otherwise go to C_POP if !rx_empty, else wait in IDLE.
// - IDLE with wr_ptr>0: idle counter increments each cycle.
//   At IDLE_CYC-1: frame_len<=wr_ptr, then D_ADDR. Counter is cleared by every captured byte.
// - IDLE with wr_ptr==0: no timeout; an empty frame is never drained.
// - Drain sequence:
//   - D_ADDR: ram_addr=rd_ptr, ram_wren=0.
//   - D_RD: holds for RAM_RD_LAT cycles, then latches tx_data=ram_rdata.
//   - D_SEND: tx_wr=1 for exactly 1 cycle.
//   - D_WAIT: waits for tx_ti, then rd_ptr++.
//   - Exit from D_WAIT: rd_ptr==frame_len -> IDLE with rd_ptr, wr_ptr and frame_len cleared; otherwise D_ADDR.
// - During drain rx_rd=0 and ram_wren=0. New RX bytes back up in the RX FIFO and are captured after the drain.
// - tx_ti outside D_WAIT is ignored. Simultaneous rx_empty fall and tx_ti: tx_ti is served, RX waits.
// - Pointer arithmetic is unsigned and never wraps within a frame. frame_len is ADDR_W+1 wide so 2**ADDR_W is representable.
// STRUCTURE
// - Package uart_sched_pkg: state encoding localparams, TERM_BYTE default, IDLE_CYC default.
// - Sub-module uart_idle_timer: clear/enable/expire counter, width = clog2(IDLE_CYC).
//   The FSM and pointers stay in this module.
// TESTING
// - "AB\r" into RX FIFO -> RAM addr 0..2 = 41,42,0D.
//   Then tx_wr pulses with tx_data 41,42,0D, each after the prior tx_ti; frame_len=3; back in IDLE.
// - "XY", no terminator -> IDLE_CYC cycles after last capture, drain starts.
//   Bytes 58,59 sent; exactly IDLE_CYC cycles, not one more.
// - 256 non-terminator bytes (ADDR_W=8) -> overflow pulses once, frame_len=256, all 256 replayed in order.
// - RX bytes arriving mid-drain -> no rx_rd and no ram_wren until IDLE.
//   Then the new bytes form the next frame; no byte lost or reordered.
// - rst asserted in D_WAIT with tx_data=42 -> all outputs 0 asynchronously.
//   After release, an empty FIFO stays IDLE with no tx_wr.
// - tx_ti injected in IDLE and C_WR -> no state or pointer change.

Source files
------------

// File: rtl/uart_sched_pkg.sv
// rtl/uart_sched_pkg.sv - state encoding and default constants for the UART frame sequencer
// Contents:
//   sched_state_t  sequencer state encoding (idle, capture pair, drain quartet)
//   TERM_BYTE_DEF  default frame terminator (carriage return)
//   IDLE_CYC_DEF   default idle timeout in clock cycles (10 ms at 48 MHz)
//   cnt_width      counter width able to hold 0 .. n-1, never narrower than 1 bit
package uart_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_C_POP  = 3'd1,
        ST_C_WR   = 3'd2,
        ST_D_ADDR = 3'd3,
        ST_D_RD   = 3'd4,
        ST_D_SEND = 3'd5,
        ST_D_WAIT = 3'd6
    } sched_state_t;

    localparam logic [7:0] TERM_BYTE_DEF = 8'h0D;
    localparam int         IDLE_CYC_DEF  = 480000;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// rtl/uart_idle_timer.sv - idle-gap counter that closes a partially captured frame
// Ports:
//   clk     in  system clock
//   rst     in  asynchronous reset, active-high
//   clr     in  restart the count (a byte was just captured)
//   en      in  count this cycle (sequencer idle with a non-empty frame)
//   expire  out high in the enabled cycle that completes IDLE_CYC idle cycles
module uart_idle_timer
    import uart_sched_pkg::*;
#(
    parameter int IDLE_CYC = IDLE_CYC_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int               CNT_W = cnt_width(IDLE_CYC);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(IDLE_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign expire = en && (cnt_q == LAST);

    // Rolls back to zero on expiry so the next frame starts from a clean count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = expire ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_frame_sched.sv
// rtl/uart_frame_sched.sv - captures UART RX bytes into a frame RAM and replays each frame to the TX
// Ports:
//   clk, rst              system clock, asynchronous active-high reset
//   rx_empty, rx_data     RX FIFO status and data (data valid the cycle after rx_rd)
//   rx_rd                 RX FIFO read pulse
//   ram_addr, ram_wdata   frame RAM address and write data
//   ram_wren, ram_rdata   frame RAM write enable and read data
//   tx_data, tx_wr        byte to transmitter and its start pulse
//   tx_ti                 transmitter done pulse
//   frame_len             length of the frame being drained, 0 otherwise
//   busy                  high whenever the sequencer is not idle
//   overflow              pulse when a frame is closed because the buffer filled
module uart_frame_sched
    import uart_sched_pkg::*;
#(
    parameter int         ADDR_W     = 8,
    parameter logic [7:0] TERM_BYTE  = TERM_BYTE_DEF,
    parameter int         IDLE_CYC   = IDLE_CYC_DEF,
    parameter int         RAM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_empty,
    input  logic [7:0]        rx_data,
    output logic              rx_rd,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    output logic              ram_wren,
    input  logic [7:0]        ram_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_wr,
    input  logic              tx_ti,
    output logic [ADDR_W:0]   frame_len,
    output logic              busy,
    output logic              overflow
);

    localparam int               PW       = ADDR_W + 1;
    localparam int               LAT_W    = cnt_width(RAM_RD_LAT);
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(RAM_RD_LAT - 1);
    localparam logic [PW-1:0]    CAPACITY = {1'b1, {ADDR_W{1'b0}}};

    sched_state_t      state_q, state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     frame_len_q, frame_len_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic              rx_rd_q, rx_rd_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_wren_q, ram_wren_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_wr_q, tx_wr_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;

    logic [PW-1:0] wr_cnt;
    logic [PW-1:0] rd_cnt;
    logic          is_term;
    logic          is_full;
    logic          timer_clr;
    logic          timer_en;
    logic          timer_expire;

    assign timer_clr = (state_q == ST_C_WR);
    assign timer_en  = (state_q == ST_IDLE) && (wr_ptr_q != '0);

    uart_idle_timer #(
        .IDLE_CYC (IDLE_CYC)
    ) u_idle_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (timer_clr),
        .en     (timer_en),
        .expire (timer_expire)
    );

    // During C_WR wr_ptr still holds the address being written, so wr_cnt
    // is the frame length if this byte closes the frame.
    assign wr_cnt  = wr_ptr_q + PW'(1);
    assign rd_cnt  = rd_ptr_q + PW'(1);
    assign is_term = (rx_data == TERM_BYTE);
    assign is_full = (wr_cnt == CAPACITY);

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        frame_len_d = frame_len_q;
        lat_d       = lat_q;
        ram_addr_d  = ram_addr_q;
        tx_data_d   = tx_data_q;
        rx_rd_d     = 1'b0;
        ram_wren_d  = 1'b0;
        tx_wr_d     = 1'b0;
        overflow_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // A pending timeout wins over a byte arriving in the same cycle;
                // that byte simply starts the next frame after the drain.
                if (timer_expire) begin
                    frame_len_d = wr_ptr_q;
                    ram_addr_d  = rd_ptr_q[ADDR_W-1:0];
                    state_d     = ST_D_ADDR;
                end else if (!rx_empty) begin
                    rx_rd_d = 1'b1;
                    state_d = ST_C_POP;
                end
            end
            ST_C_POP: begin
                ram_addr_d = wr_ptr_q[ADDR_W-1:0];
                ram_wren_d = 1'b1;
                state_d    = ST_C_WR;
            end
            ST_C_WR: begin
                wr_ptr_d = wr_cnt;
                if (is_term || is_full) begin
                    frame_len_d = wr_cnt;
                    // A terminator landing in the last slot closes the frame normally.
                    overflow_d  = is_full && !is_term;
                    ram_addr_d  = rd_ptr_q[ADDR_W-1:0];
                    state_d     = ST_D_ADDR;
                end else if (!rx_empty) begin
                    rx_rd_d = 1'b1;
                    state_d = ST_C_POP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_D_ADDR: begin
                lat_d   = '0;
                state_d = ST_D_RD;
            end
            ST_D_RD: begin
                if (lat_q == LAT_LAST) begin
                    tx_data_d = ram_rdata;
                    tx_wr_d   = 1'b1;
                    state_d   = ST_D_SEND;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            ST_D_SEND: begin
                state_d = ST_D_WAIT;
            end
            ST_D_WAIT: begin
                if (tx_ti) begin
                    if (rd_cnt == frame_len_q) begin
                        rd_ptr_d    = '0;
                        wr_ptr_d    = '0;
                        frame_len_d = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        rd_ptr_d   = rd_cnt;
                        ram_addr_d = rd_cnt[ADDR_W-1:0];
                        state_d    = ST_D_ADDR;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_len_q <= '0;
            lat_q       <= '0;
            rx_rd_q     <= 1'b0;
            ram_addr_q  <= '0;
            ram_wren_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_wr_q     <= 1'b0;
            busy_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_len_q <= frame_len_d;
            lat_q       <= lat_d;
            rx_rd_q     <= rx_rd_d;
            ram_addr_q  <= ram_addr_d;
            ram_wren_q  <= ram_wren_d;
            tx_data_q   <= tx_data_d;
            tx_wr_q     <= tx_wr_d;
            busy_q      <= busy_d;
            overflow_q  <= overflow_d;
        end
    end

    // rx_data only becomes valid in the write cycle, so it is steered straight
    // through while the write strobe is up and forced to zero otherwise.
    assign ram_wdata = ram_wren_q ? rx_data : 8'h00;
    assign rx_rd     = rx_rd_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wren  = ram_wren_q;
    assign tx_data   = tx_data_q;
    assign tx_wr     = tx_wr_q;
    assign frame_len = frame_len_q;
    assign busy      = busy_q;
    assign overflow  = overflow_q;

endmodule
